assoc_mem_multichannel: RTL and testbench
=========================================

ASSOC_MEM_MULTICHANNEL -- requirements
Module: assoc_mem_multichannel

Interface
REQ-001 SHALL have parameter HV_DIMENSION, default 2048, hypervector width in bits.
REQ-002 SHALL have parameter AM_CHUNK, default 256, popcount slice width; HV_DIMENSION is an integer multiple of AM_CHUNK; NCHUNK = HV_DIMENSION/AM_CHUNK.
REQ-003 SHALL have parameter CLASSES, default 4, prototypes per channel (>=2).
REQ-004 SHALL have parameter CHANNELS, default 2, independent prototype sets searched in parallel.
REQ-005 SHALL have derived parameters LABEL_WIDTH = ceilLog2(CLASSES) and DISTANCE_WIDTH = ceilLog2(HV_DIMENSION+1).
REQ-006 SHALL have Clk_CI  in  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have Reset_RBI  in  1  synchronous, active-low reset.
REQ-008 SHALL have ValidIn_SI  in  1  query valid.
REQ-009 SHALL have ReadyOut_SO  out  1  query accept.
REQ-010 SHALL have HypervectorIn_DI  in  HV_DIMENSION  query hypervector.
REQ-011 SHALL have ValidOut_SO  out  1  result valid.
REQ-012 SHALL have ReadyIn_SI  in  1  downstream accept.
REQ-013 SHALL have LabelOut_DO  out  CHANNELS*LABEL_WIDTH  winning class per channel; channel k in bits [k*LABEL_WIDTH +: LABEL_WIDTH].
REQ-014 SHALL have DistanceOut_DO  out  CHANNELS*DISTANCE_WIDTH  winning Hamming distance per channel, same packing.
REQ-015 SHALL have WrEn_SI  in  1  prototype write strobe.
REQ-016 SHALL have WrChannel_DI  in  ceilLog2(CHANNELS) (min 1)  write target channel.
REQ-017 SHALL have WrClass_DI  in  LABEL_WIDTH  write target class.
REQ-018 SHALL have WrData_DI  in  HV_DIMENSION  prototype data.

Function
REQ-019 SHALL implement FSM states IDLE, SEARCH, DONE.
REQ-020 In IDLE, ReadyOut_SO SHALL equal ~WrEn_SI; writes have priority over queries in the same cycle.
REQ-021 A write with WrEn_SI=1 in IDLE SHALL update prototype[WrChannel_DI][WrClass_DI] at the edge; WrEn_SI outside IDLE, or out-of-range channel/class, SHALL be ignored.
REQ-022 IDLE->SEARCH SHALL occur on ValidIn_SI & ReadyOut_SO, latching HypervectorIn_DI into the query register and clearing class/chunk counters and accumulators.
REQ-023 Each SEARCH cycle SHALL add popcount(query XOR prototype slice) for one AM_CHUNK slice, for every channel in parallel; classes are scanned 0..CLASSES-1, chunks 0..NCHUNK-1 within each class.
REQ-024 On the last chunk of a class, the complete distance SHALL be compared against the channel's best: class 0 loads unconditionally; later classes replace only if strictly smaller (ties keep the lower label).
REQ-025 SEARCH SHALL last exactly CLASSES*NCHUNK cycles, then transition to DONE, loading LabelOut_DO/DistanceOut_DO.
REQ-026 ValidOut_SO SHALL be 1 only in DONE; with handshake in cycle t, ValidOut_SO first rises in cycle t+CLASSES*NCHUNK+1 (33 at defaults).
REQ-027 DONE->IDLE SHALL occur on ReadyIn_SI=1; outputs SHALL hold stable while ValidOut_SO=1 and retain values until the next DONE load.
REQ-028 ReadyOut_SO SHALL be 0 in SEARCH and DONE; ValidIn_SI there SHALL have no effect.
REQ-029 Accumulators SHALL be DISTANCE_WIDTH wide and never overflow (max value HV_DIMENSION).

Reset
REQ-030 While Reset_RBI=0 at an edge: state=IDLE, counters=0, accumulators=0, query register=0, LabelOut_DO=0, DistanceOut_DO=0; ValidOut_SO=0 in the following cycle.
REQ-031 Reset during SEARCH or DONE SHALL abort the search with no result emitted.
REQ-032 Prototype memory SHALL NOT be reset; contents persist across reset.

Verification
REQ-033 Write ch0 classes 0..3 = all-0, all-1, alternating 01.., 0; query all-0 -> ch0 label 0, distance 0 (tie with class 3 keeps 0); ValidOut_SO rises 33 cycles after handshake.
REQ-034 Ch1 prototypes with 5, 100, 3, 3 set bits; query all-0 -> ch1 label 2, distance 3, concurrent with ch0 result.
REQ-035 Query all-1 vs ch0 all-0 in class 0 -> distance 2048 for that class, no overflow; label 1 distance 0.
REQ-036 Hold ReadyIn_SI=0 for 10 cycles in DONE, assert ValidIn_SI -> outputs stable, ValidOut_SO=1, ReadyOut_SO=0; release -> IDLE next cycle.
REQ-037 WrEn_SI and ValidIn_SI both 1 in IDLE -> write committed, query not accepted; next cycle query accepted and sees new prototype.
REQ-038 Reset_RBI=0 at SEARCH cycle 10 -> IDLE, outputs 0, no ValidOut_SO; subsequent query uses prototypes written before reset.

Source files
------------

// File: rtl/assoc_mem_multichannel.sv
// Associative memory: finds, per channel, the stored prototype closest in
// Hamming distance to a query hypervector. One AM_CHUNK slice of every
// channel is compared per cycle; all channels are searched in lock-step.
module assoc_mem_multichannel #(
    parameter int unsigned  HV_DIMENSION   = 2048,
    parameter int unsigned  AM_CHUNK       = 256,
    parameter int unsigned  CLASSES        = 4,
    parameter int unsigned  CHANNELS       = 2,
    localparam int unsigned LABEL_WIDTH    = $clog2(CLASSES),
    localparam int unsigned DISTANCE_WIDTH = $clog2(HV_DIMENSION + 1),
    localparam int unsigned CHANNEL_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                                Clk_CI,
    input  logic                                Reset_RBI,
    input  logic                                ValidIn_SI,
    output logic                                ReadyOut_SO,
    input  logic [HV_DIMENSION-1:0]             HypervectorIn_DI,
    output logic                                ValidOut_SO,
    input  logic                                ReadyIn_SI,
    output logic [CHANNELS*LABEL_WIDTH-1:0]     LabelOut_DO,
    output logic [CHANNELS*DISTANCE_WIDTH-1:0]  DistanceOut_DO,
    input  logic                                WrEn_SI,
    input  logic [CHANNEL_WIDTH-1:0]            WrChannel_DI,
    input  logic [LABEL_WIDTH-1:0]              WrClass_DI,
    input  logic [HV_DIMENSION-1:0]             WrData_DI
);

    localparam int unsigned NCHUNK      = HV_DIMENSION / AM_CHUNK;
    localparam int unsigned CHUNK_WIDTH = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t                      State_SP, State_SN;
    logic [HV_DIMENSION-1:0]     Prototype_DP [CHANNELS][CLASSES];
    logic [HV_DIMENSION-1:0]     Query_DP;
    logic [LABEL_WIDTH-1:0]      ClassCnt_DP;
    logic [CHUNK_WIDTH-1:0]      ChunkCnt_DP;
    logic [DISTANCE_WIDTH-1:0]   Acc_DP       [CHANNELS];
    logic [DISTANCE_WIDTH-1:0]   BestDist_DP  [CHANNELS];
    logic [LABEL_WIDTH-1:0]      BestLabel_DP [CHANNELS];
    logic [CHANNELS*LABEL_WIDTH-1:0]    LabelOut_DP;
    logic [CHANNELS*DISTANCE_WIDTH-1:0] DistanceOut_DP;

    logic [DISTANCE_WIDTH-1:0]   Sum_D           [CHANNELS];
    logic [DISTANCE_WIDTH-1:0]   NextBestDist_D  [CHANNELS];
    logic [LABEL_WIDTH-1:0]      NextBestLabel_D [CHANNELS];
    logic                        LastChunk_S, LastClass_S, Accept_S, WrHit_S;
    int unsigned                 ChunkOffset_D;

    assign LabelOut_DO    = LabelOut_DP;
    assign DistanceOut_DO = DistanceOut_DP;

    assign LastChunk_S = (ChunkCnt_DP == CHUNK_WIDTH'(NCHUNK - 1));
    assign LastClass_S = (ClassCnt_DP == LABEL_WIDTH'(CLASSES - 1));
    assign Accept_S    = (State_SP == IDLE) && ValidIn_SI && !WrEn_SI;
    assign WrHit_S     = (State_SP == IDLE) && WrEn_SI
                         && (32'(WrChannel_DI) < CHANNELS) && (32'(WrClass_DI) < CLASSES);

    function automatic logic [DISTANCE_WIDTH-1:0] popCount(input logic [AM_CHUNK-1:0] Vec_D);
        logic [DISTANCE_WIDTH-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < AM_CHUNK; i++) begin
            cnt = cnt + DISTANCE_WIDTH'(Vec_D[i]);
        end
        return cnt;
    endfunction

    // State register
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            State_SP <= IDLE;
        end else begin
            State_SP <= State_SN;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        State_SN    = State_SP;
        ReadyOut_SO = 1'b0;
        ValidOut_SO = 1'b0;
        case (State_SP)
            IDLE: begin
                ReadyOut_SO = !WrEn_SI;
                if (Accept_S) State_SN = SEARCH;
            end
            SEARCH: begin
                if (LastChunk_S && LastClass_S) State_SN = DONE;
            end
            DONE: begin
                ValidOut_SO = 1'b1;
                if (ReadyIn_SI) State_SN = IDLE;
            end
            default: State_SN = IDLE;
        endcase
    end

    // Per-channel partial distance and running best for the current slice
    always_comb begin
        ChunkOffset_D = 32'(ChunkCnt_DP) * AM_CHUNK;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            Sum_D[c] = Acc_DP[c]
                       + popCount(Query_DP[ChunkOffset_D +: AM_CHUNK]
                                  ^ Prototype_DP[c][ClassCnt_DP][ChunkOffset_D +: AM_CHUNK]);
            NextBestDist_D[c]  = BestDist_DP[c];
            NextBestLabel_D[c] = BestLabel_DP[c];
            // strict less-than keeps the lower label on ties
            if (LastChunk_S && ((ClassCnt_DP == '0) || (Sum_D[c] < BestDist_DP[c]))) begin
                NextBestDist_D[c]  = Sum_D[c];
                NextBestLabel_D[c] = ClassCnt_DP;
            end
        end
    end

    // Prototype storage; deliberately not reset so contents survive reset
    always_ff @(posedge Clk_CI) begin
        if (WrHit_S) begin
            Prototype_DP[WrChannel_DI][WrClass_DI] <= WrData_DI;
        end
    end

    // Query capture, scan counters, accumulators and result registers
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            Query_DP       <= '0;
            ClassCnt_DP    <= '0;
            ChunkCnt_DP    <= '0;
            LabelOut_DP    <= '0;
            DistanceOut_DP <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                Acc_DP[c]       <= '0;
                BestDist_DP[c]  <= '0;
                BestLabel_DP[c] <= '0;
            end
        end else begin
            case (State_SP)
                IDLE: begin
                    if (Accept_S) begin
                        Query_DP    <= HypervectorIn_DI;
                        ClassCnt_DP <= '0;
                        ChunkCnt_DP <= '0;
                        for (int unsigned c = 0; c < CHANNELS; c++) begin
                            Acc_DP[c] <= '0;
                        end
                    end
                end
                SEARCH: begin
                    ChunkCnt_DP <= LastChunk_S ? '0 : ChunkCnt_DP + CHUNK_WIDTH'(1);
                    if (LastChunk_S) begin
                        ClassCnt_DP <= LastClass_S ? '0 : ClassCnt_DP + LABEL_WIDTH'(1);
                    end
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        Acc_DP[c]       <= LastChunk_S ? '0 : Sum_D[c];
                        BestDist_DP[c]  <= NextBestDist_D[c];
                        BestLabel_DP[c] <= NextBestLabel_D[c];
                        if (LastChunk_S && LastClass_S) begin
                            LabelOut_DP[c*LABEL_WIDTH +: LABEL_WIDTH]          <= NextBestLabel_D[c];
                            DistanceOut_DP[c*DISTANCE_WIDTH +: DISTANCE_WIDTH] <= NextBestDist_D[c];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_mem_multichannel.sv
// Directed bench for assoc_mem_multichannel at default parameters.
// Expected results come from a behavioural model of the prototype memory.
module tb_assoc_mem_multichannel;

    localparam int unsigned HV  = 2048;
    localparam int unsigned LAT = 33;

    logic            Clk_CI = 1'b0;
    logic            Reset_RBI;
    logic            ValidIn_SI;
    logic            ReadyOut_SO;
    logic [HV-1:0]   HypervectorIn_DI;
    logic            ValidOut_SO;
    logic            ReadyIn_SI;
    logic [3:0]      LabelOut_DO;
    logic [23:0]     DistanceOut_DO;
    logic            WrEn_SI;
    logic [0:0]      WrChannel_DI;
    logic [1:0]      WrClass_DI;
    logic [HV-1:0]   WrData_DI;

    typedef struct packed {
        logic [1:0]  lab1;
        logic [1:0]  lab0;
        logic [11:0] dist1;
        logic [11:0] dist0;
    } exp_t;

    logic [HV-1:0] protoM [2][4];
    exp_t          expQ [$];
    int            passCnt = 0;
    int            totalCnt = 0;

    assoc_mem_multichannel dut (
        .Clk_CI           (Clk_CI),
        .Reset_RBI        (Reset_RBI),
        .ValidIn_SI       (ValidIn_SI),
        .ReadyOut_SO      (ReadyOut_SO),
        .HypervectorIn_DI (HypervectorIn_DI),
        .ValidOut_SO      (ValidOut_SO),
        .ReadyIn_SI       (ReadyIn_SI),
        .LabelOut_DO      (LabelOut_DO),
        .DistanceOut_DO   (DistanceOut_DO),
        .WrEn_SI          (WrEn_SI),
        .WrChannel_DI     (WrChannel_DI),
        .WrClass_DI       (WrClass_DI),
        .WrData_DI        (WrData_DI)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    function automatic exp_t model(input logic [HV-1:0] q);
        exp_t e;
        int   best [2];
        int   lab  [2];
        for (int c = 0; c < 2; c++) begin
            best[c] = $countones(q ^ protoM[c][0]);
            lab[c]  = 0;
            for (int k = 1; k < 4; k++) begin
                if ($countones(q ^ protoM[c][k]) < best[c]) begin
                    best[c] = $countones(q ^ protoM[c][k]);
                    lab[c]  = k;
                end
            end
        end
        e.lab0  = 2'(lab[0]);
        e.lab1  = 2'(lab[1]);
        e.dist0 = 12'(best[0]);
        e.dist1 = 12'(best[1]);
        return e;
    endfunction

    function automatic logic [HV-1:0] rndHv();
        logic [HV-1:0] v;
        for (int i = 0; i < HV / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [HV-1:0] lowOnes(input int n);
        logic [HV-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic writeProto(input int ch, input int cls, input logic [HV-1:0] d);
        WrEn_SI      = 1'b1;
        WrChannel_DI = 1'(ch);
        WrClass_DI   = 2'(cls);
        WrData_DI    = d;
        tick();
        WrEn_SI = 1'b0;
        protoM[ch][cls] = d;
    endtask

    task automatic compareOut(input string tag, input exp_t e);
        check({tag, "_lab0"},  64'(LabelOut_DO[1:0]),     64'(e.lab0));
        check({tag, "_lab1"},  64'(LabelOut_DO[3:2]),     64'(e.lab1));
        check({tag, "_dist0"}, 64'(DistanceOut_DO[11:0]), 64'(e.dist0));
        check({tag, "_dist1"}, 64'(DistanceOut_DO[23:12]),64'(e.dist1));
    endtask

    // Handshake a query; the expected result is queued on acceptance.
    task automatic startQuery(input string tag, input logic [HV-1:0] q);
        ValidIn_SI       = 1'b1;
        HypervectorIn_DI = q;
        #1;
        check({tag, "_ready"}, 64'(ReadyOut_SO), 64'd1);
        expQ.push_back(model(q));
        tick();
        ValidIn_SI = 1'b0;
    endtask

    // Wait (bounded) for the result, pop the scoreboard and compare.
    task automatic finishQuery(input string tag, input bit holdDone);
        int   n;
        exp_t e;
        n = 1;
        while (ValidOut_SO !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        check({tag, "_sb"}, 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            compareOut(tag, e);
        end
        if (!holdDone) tick();
    endtask

    initial begin
        exp_t e;
        logic [HV-1:0] q;
        logic [HV-1:0] alt;
        bit saw;

        Reset_RBI        = 1'b0;
        ValidIn_SI       = 1'b0;
        HypervectorIn_DI = '0;
        ReadyIn_SI       = 1'b1;
        WrEn_SI          = 1'b0;
        WrChannel_DI     = '0;
        WrClass_DI       = '0;
        WrData_DI        = '0;
        tick();
        tick();
        check("rst_valid", 64'(ValidOut_SO),    64'd0);
        check("rst_ready", 64'(ReadyOut_SO),    64'd1);
        check("rst_label", 64'(LabelOut_DO),    64'd0);
        check("rst_dist",  64'(DistanceOut_DO), 64'd0);
        Reset_RBI = 1'b1;
        tick();

        // Channel 0: zeros, ones, alternating, zeros
        for (int i = 0; i < HV / 2; i++) alt[2*i +: 2] = 2'b01;
        writeProto(0, 0, '0);
        writeProto(0, 1, '1);
        writeProto(0, 2, alt);
        writeProto(0, 3, '0);
        // Channel 1: 5, 100, 3, 3 set bits at differing positions
        writeProto(1, 0, lowOnes(5));
        writeProto(1, 1, lowOnes(100));
        q = '0; q[2047] = 1'b1; q[1024] = 1'b1; q[300] = 1'b1;
        writeProto(1, 2, q);
        writeProto(1, 3, lowOnes(3));

        // All-zero query: ties resolve to the lower label
        startQuery("q0", '0);
        finishQuery("q0", 1'b0);

        // All-one query: class-0 distance is the full width
        startQuery("q1", '1);
        finishQuery("q1", 1'b0);

        // Random queries
        for (int r = 0; r < 3; r++) begin
            startQuery("qr", rndHv());
            finishQuery("qr", 1'b0);
        end

        // Back-pressure in DONE: outputs hold, new queries refused
        ReadyIn_SI = 1'b0;
        q = rndHv();
        e = model(q);
        startQuery("bp", q);
        finishQuery("bp", 1'b1);
        for (int i = 0; i < 10; i++) begin
            ValidIn_SI       = 1'b1;
            HypervectorIn_DI = rndHv();
            tick();
            check("bp_valid", 64'(ValidOut_SO), 64'd1);
            check("bp_ready", 64'(ReadyOut_SO), 64'd0);
            compareOut("bp_hold", e);
        end
        ValidIn_SI = 1'b0;
        ReadyIn_SI = 1'b1;
        tick();
        check("bp_rel_valid", 64'(ValidOut_SO), 64'd0);
        check("bp_rel_ready", 64'(ReadyOut_SO), 64'd1);
        compareOut("bp_retain", e);

        // Write and query in the same cycle: write wins, query waits
        WrEn_SI          = 1'b1;
        WrChannel_DI     = 1'b0;
        WrClass_DI       = 2'd0;
        WrData_DI        = '1;
        ValidIn_SI       = 1'b1;
        HypervectorIn_DI = '1;
        #1;
        check("wq_ready", 64'(ReadyOut_SO), 64'd0);
        tick();
        WrEn_SI = 1'b0;
        protoM[0][0] = '1;
        startQuery("wq", '1);
        finishQuery("wq", 1'b0);

        // Reset in the middle of a search
        startQuery("rs", rndHv());
        for (int i = 0; i < 9; i++) tick();
        Reset_RBI = 1'b0;
        tick();
        Reset_RBI = 1'b1;
        void'(expQ.pop_front());
        check("rs_valid", 64'(ValidOut_SO),    64'd0);
        check("rs_ready", 64'(ReadyOut_SO),    64'd1);
        check("rs_label", 64'(LabelOut_DO),    64'd0);
        check("rs_dist",  64'(DistanceOut_DO), 64'd0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ValidOut_SO === 1'b1) saw = 1'b1;
        end
        check("rs_no_result", 64'(saw), 64'd0);
        startQuery("rs_after", rndHv());
        finishQuery("rs_after", 1'b0);

        // Maximum distance: every channel-0 prototype is all ones
        writeProto(0, 2, '1);
        writeProto(0, 3, '1);
        startQuery("max", '0);
        finishQuery("max", 1'b0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
